// File: rtl/dbg_commit_trace.sv
// Commit-trace FIFO between retire and the debug host, with halt FSM and counters.
// Drop or stall on full; retire and drop counters.
module dbg_commit_trace #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 8,
  parameter int CSR_AW       = 12,
  parameter int DROP_ON_FULL = 0,
  parameter int CNT_W        = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cm_valid,
  output logic                       cm_ready,
  input  logic [XLEN-1:0]            cm_pc,
  input  logic [XLEN-1:0]            cm_inst,
  input  logic                       cm_gpr_wen,
  input  logic [4:0]                 cm_gpr_waddr,
  input  logic [XLEN-1:0]            cm_gpr_wdata,
  input  logic                       cm_csr_wen,
  input  logic [CSR_AW-1:0]          cm_csr_waddr,
  input  logic [XLEN-1:0]            cm_csr_wdata,
  input  logic                       cm_brk,
  input  logic                       cm_ivd,
  output logic                       tr_valid,
  input  logic                       tr_ready,
  output logic [4*XLEN+CSR_AW+8:0]   tr_rec,
  input  logic                       resume,
  output logic                       halted,
  output logic [1:0]                 halt_cause,
  output logic [CNT_W-1:0]           retire_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 4*XLEN + CSR_AW + 9;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state_q;
  logic [1:0]       cause_q;
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [RW-1:0]    mem_q [DEPTH];
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic          full, empty;
  logic          pop, acc, wr, drop, trap;
  logic [RW-1:0] rec_in;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign rec_in = {cm_brk, cm_ivd,
                   cm_csr_wen, cm_csr_waddr, cm_csr_wdata,
                   cm_gpr_wen, cm_gpr_waddr, cm_gpr_wdata,
                   cm_inst, cm_pc};

  always_comb begin
    cm_ready = 1'b0;
    if (state_q == RUN)
      cm_ready = (DROP_ON_FULL != 0) ? 1'b1 : !full;
  end

  // In drop mode a pop in the same cycle frees the slot for the push.
  assign pop  = !empty && tr_ready;
  assign acc  = cm_valid && cm_ready;
  assign wr   = acc && (!full || pop);
  assign drop = acc && full && !pop;
  assign trap = wr && (cm_brk || cm_ivd);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ret_d  = ret_q;
    drop_d = drop_q;
    if (wr) begin
      wptr_d = wptr_q + (AW+1)'(1);
      ret_d  = ret_q + CNT_W'(1);
    end
    if (pop)
      rptr_d = rptr_q + (AW+1)'(1);
    if (drop && (drop_q != {CNT_W{1'b1}}))
      drop_d = drop_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ret_q  <= '0;
      drop_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ret_q  <= ret_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem_q[wptr_q[AW-1:0]] <= rec_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cause_q <= 2'b00;
    end else begin
      unique case (state_q)
        RUN: begin
          if (trap) begin
            state_q <= DRAIN;
            cause_q <= cm_ivd ? 2'b10 : 2'b01;
          end
        end
        DRAIN: begin
          if (empty)
            state_q <= HALT;
        end
        HALT: begin
          if (resume) begin
            state_q <= RUN;
            cause_q <= 2'b00;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign tr_valid   = !empty;
  assign tr_rec     = mem_q[rptr_q[AW-1:0]];
  assign halted     = (state_q == HALT);
  assign halt_cause = cause_q;
  assign retire_cnt = ret_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_dbg_commit_trace.sv
// Scoreboard bench for dbg_commit_trace: stall and drop instances side by side.
// Expected records are queued on push and compared on each observed pop.
module tb_dbg_commit_trace;

  localparam int RW = 149;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        cm_valid = 1'b0;
  logic        tr_ready = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] cm_pc, cm_inst, cm_gpr_wdata, cm_csr_wdata;
  logic        cm_gpr_wen, cm_csr_wen, cm_brk, cm_ivd;
  logic [4:0]  cm_gpr_waddr;
  logic [11:0] cm_csr_waddr;

  logic          rdy_s, tv_s, hlt_s, rdy_d, tv_d, hlt_d;
  logic [RW-1:0] rec_s, rec_d;
  logic [1:0]    cause_s, cause_d;
  logic [31:0]   ret_s, drp_s, ret_d, drp_d;

  logic          cur_ready, cur_tv, cur_halted;
  logic [RW-1:0] cur_rec;
  logic [1:0]    cur_cause;
  logic [31:0]   cur_ret, cur_drop;

  logic [RW-1:0] q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbg_commit_trace #(.DROP_ON_FULL(0)) u_stall (
    .clk(clk), .reset(reset),
    .cm_valid(cm_valid & ~sel), .cm_ready(rdy_s),
    .cm_pc(cm_pc), .cm_inst(cm_inst),
    .cm_gpr_wen(cm_gpr_wen), .cm_gpr_waddr(cm_gpr_waddr),
    .cm_gpr_wdata(cm_gpr_wdata),
    .cm_csr_wen(cm_csr_wen), .cm_csr_waddr(cm_csr_waddr),
    .cm_csr_wdata(cm_csr_wdata),
    .cm_brk(cm_brk), .cm_ivd(cm_ivd),
    .tr_valid(tv_s), .tr_ready(tr_ready & ~sel), .tr_rec(rec_s),
    .resume(resume & ~sel), .halted(hlt_s), .halt_cause(cause_s),
    .retire_cnt(ret_s), .drop_cnt(drp_s)
  );

  dbg_commit_trace #(.DROP_ON_FULL(1)) u_drop (
    .clk(clk), .reset(reset),
    .cm_valid(cm_valid & sel), .cm_ready(rdy_d),
    .cm_pc(cm_pc), .cm_inst(cm_inst),
    .cm_gpr_wen(cm_gpr_wen), .cm_gpr_waddr(cm_gpr_waddr),
    .cm_gpr_wdata(cm_gpr_wdata),
    .cm_csr_wen(cm_csr_wen), .cm_csr_waddr(cm_csr_waddr),
    .cm_csr_wdata(cm_csr_wdata),
    .cm_brk(cm_brk), .cm_ivd(cm_ivd),
    .tr_valid(tv_d), .tr_ready(tr_ready & sel), .tr_rec(rec_d),
    .resume(resume & sel), .halted(hlt_d), .halt_cause(cause_d),
    .retire_cnt(ret_d), .drop_cnt(drp_d)
  );

  assign cur_ready  = sel ? rdy_d   : rdy_s;
  assign cur_tv     = sel ? tv_d    : tv_s;
  assign cur_rec    = sel ? rec_d   : rec_s;
  assign cur_halted = sel ? hlt_d   : hlt_s;
  assign cur_cause  = sel ? cause_d : cause_s;
  assign cur_ret    = sel ? ret_d   : ret_s;
  assign cur_drop   = sel ? drp_d   : drp_s;

  task automatic check(input string tag, input logic [RW-1:0] got,
                       input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk_rec(input logic [31:0] pc,
                                           input logic b, input logic iv);
    return {b, iv, pc[3], pc[13:2], pc + 32'd1,
            pc[2], pc[6:2], ~pc, pc ^ 32'h13, pc};
  endfunction

  function automatic logic [31:0] pcn(input int i);
    return 32'h8000_0000 + 32'(4 * i);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [31:0] pc, input logic b,
                            input logic iv);
    cm_pc = pc;
    cm_inst = pc ^ 32'h13;
    cm_gpr_wen = pc[2];
    cm_gpr_waddr = pc[6:2];
    cm_gpr_wdata = ~pc;
    cm_csr_wen = pc[3];
    cm_csr_waddr = pc[13:2];
    cm_csr_wdata = pc + 32'd1;
    cm_brk = b;
    cm_ivd = iv;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [31:0] pc, input logic b, input logic iv,
                      input logic wr);
    bit done = 0;
    set_fields(pc, b, iv);
    cm_valid = 1'b1;
    for (int n = 0; n < 8 && !done; n++) begin
      @(negedge clk);
      if (cur_ready) begin
        if (wr) q.push_back(mk_rec(pc, b, iv));
        done = 1;
      end
      cyc();
    end
    if (!done) check("accept_timeout", 0, 1);
    cm_valid = 1'b0;
  endtask

  // Returns on the first falling edge with tr_valid low.
  task automatic wait_drain();
    bit done = 0;
    tr_ready = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (!cur_tv) done = 1;
      else cyc();
    end
    if (!done) check("drain_timeout", 0, 1);
    check("drain_queue", RW'(q.size()), 0);
  endtask

  task automatic rst();
    reset = 1'b1;
    cm_valid = 1'b0;
    tr_ready = 1'b0;
    resume = 1'b0;
    set_fields(32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
  endtask

  always @(negedge clk) begin
    if (!reset && cur_tv && tr_ready) begin
      if (q.size() == 0) check("pop_unexpected", 1, 0);
      else check("rec", cur_rec, q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // in-order pass-through, reset state
    sel = 1'b0;
    rst();
    @(negedge clk);
    check("rst_tv", cur_tv, 0);
    check("rst_ready", cur_ready, 1);
    check("rst_halted", cur_halted, 0);
    check("rst_cause", cur_cause, 0);
    check("rst_ret", cur_ret, 0);
    check("rst_drop", cur_drop, 0);
    cyc();
    tr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lat_tv0", cur_tv, 0);
      cyc();
      push(pcn(i), 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("lat_tv1", cur_tv, 1);
      cyc();
    end
    @(negedge clk);
    check("t1_ret", cur_ret, 3);
    check("t1_queue", RW'(q.size()), 0);
    cyc();

    // stall mode fill and release
    rst();
    for (int i = 0; i < 8; i++) push(pcn(i), 1'b0, 1'b0, 1'b1);
    set_fields(pcn(8), 1'b0, 1'b0);
    cm_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("full_ready", cur_ready, 0);
      cyc();
    end
    @(negedge clk);
    check("full_ret", cur_ret, 8);
    cyc();
    tr_ready = 1'b1;
    push(pcn(8), 1'b0, 1'b0, 1'b1);
    push(pcn(9), 1'b0, 1'b0, 1'b1);
    wait_drain();
    check("t2_ret", cur_ret, 10);
    check("t2_drop", cur_drop, 0);
    cyc();

    // drop mode
    sel = 1'b1;
    rst();
    for (int i = 0; i < 10; i++) push(pcn(i), 1'b0, 1'b0, i < 8);
    @(negedge clk);
    check("drop_cnt2", cur_drop, 2);
    check("drop_ret8", cur_ret, 8);
    cyc();
    wait_drain();
    cyc();

    rst();
    for (int i = 0; i < 8; i++) push(pcn(i), 1'b0, 1'b0, 1'b1);
    tr_ready = 1'b1;
    push(pcn(8), 1'b0, 1'b0, 1'b1);
    tr_ready = 1'b0;
    @(negedge clk);
    check("drop_pop9", cur_drop, 0);
    cyc();
    push(pcn(9), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("drop_pop10", cur_drop, 1);
    check("drop_ret9", cur_ret, 9);
    cyc();
    wait_drain();
    cyc();

    // ebreak halt and resume
    sel = 1'b0;
    rst();
    push(pcn(20), 1'b0, 1'b0, 1'b1);
    push(pcn(21), 1'b0, 1'b0, 1'b1);
    push(pcn(22), 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("brk_ready", cur_ready, 0);
    check("brk_halted0", cur_halted, 0);
    check("brk_cause", cur_cause, 2'b01);
    cyc();
    wait_drain();
    check("brk_empty_halted", cur_halted, 0);
    @(negedge clk);
    check("brk_halted", cur_halted, 1);
    check("brk_halt_cause", cur_cause, 2'b01);
    check("brk_halt_ready", cur_ready, 0);
    cyc();
    resume = 1'b1;
    @(negedge clk);
    check("res_pre", cur_halted, 1);
    cyc();
    resume = 1'b0;
    @(negedge clk);
    check("res_halted", cur_halted, 0);
    check("res_ready", cur_ready, 1);
    check("res_cause", cur_cause, 0);
    check("res_ret", cur_ret, 3);
    cyc();

    // ivd wins over brk
    rst();
    tr_ready = 1'b1;
    push(pcn(30), 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("ivd_cause", cur_cause, 2'b10);
    check("ivd_ready", cur_ready, 0);
    cyc();
    wait_drain();
    @(negedge clk);
    check("ivd_halted", cur_halted, 1);
    cyc();
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    @(negedge clk);
    check("ivd_resumed", cur_halted, 0);
    check("ivd_cause_clr", cur_cause, 0);
    cyc();

    // asynchronous reset while draining
    rst();
    for (int i = 0; i < 4; i++) push(pcn(40 + i), 1'b0, 1'b0, 1'b1);
    push(pcn(44), 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("ar_ret5", cur_ret, 5);
    check("ar_tv", cur_tv, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_tv0", cur_tv, 0);
    check("ar_halted", cur_halted, 0);
    check("ar_ret0", cur_ret, 0);
    check("ar_drop0", cur_drop, 0);
    check("ar_cause", cur_cause, 0);
    check("ar_ready", cur_ready, 1);
    q.delete();
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("ar_after_tv", cur_tv, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbg_commit_trace.md
Name: dbg_commit_trace

Overview:
- Parametrised commit-trace buffer between the core's retire stage and the simulation debugger/difftest host.
- Captures each retired instruction (pc, inst, GPR write, CSR write, ebreak/invalid flags) as one record in a DEPTH-entry FIFO and drains it over a valid/ready port.
- Adds what a per-cycle event tap cannot: backpressure or drop mode, a halt state machine on ebreak/invalid instruction, and a retire counter.

Parameters:
- XLEN, 32, width of pc, inst, GPR and CSR data.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CSR_AW, 12, CSR address width (GPR address is fixed at 5 bits).
- DROP_ON_FULL, 0, 0 = stall the core when full; 1 = drop the record and count it.
- CNT_W, 32, width of the retire and drop counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cm_valid  in  1  retire event this cycle.
- cm_ready  out  1  record accepted; the core stalls retire while low.
- cm_pc  in  XLEN  retired pc.
- cm_inst  in  XLEN  retired instruction.
- cm_gpr_wen  in  1  GPR write flag.
- cm_gpr_waddr  in  5  GPR write address.
- cm_gpr_wdata  in  XLEN  GPR write data.
- cm_csr_wen  in  1  CSR write flag.
- cm_csr_waddr  in  CSR_AW  CSR write address.
- cm_csr_wdata  in  XLEN  CSR write data.
- cm_brk  in  1  retired instruction is ebreak.
- cm_ivd  in  1  retired instruction is invalid.
- tr_valid  out  1  record at FIFO head.
- tr_ready  in  1  host consumes the head record.
- tr_rec  out  packed  {brk, ivd, csr_wen, csr_waddr, csr_wdata, gpr_wen, gpr_waddr, gpr_wdata, inst, pc}, pc in the LSBs.
- resume  in  1  pulse: leave HALT.
- halted  out  1  in HALT state.
- halt_cause  out  2  01 = ebreak, 10 = invalid, 00 = none.
- retire_cnt  out  CNT_W  records accepted.
- drop_cnt  out  CNT_W  records dropped (always 0 when DROP_ON_FULL=0).

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, state RUN.
  - tr_valid=0, cm_ready=1, halted=0, halt_cause=00, both counters 0.
  - Asserting reset mid-operation discards FIFO contents immediately.
- Accept rule: a record is accepted when cm_valid && cm_ready. Write to the FIFO the same cycle; tr_valid is high the next cycle, giving 1 cycle of latency when empty.
- cm_ready:
  - State RUN: cm_ready = !full when DROP_ON_FULL=0; cm_ready = 1 when DROP_ON_FULL=1.
  - States DRAIN and HALT: cm_ready=0.
- Drop mode: if cm_valid arrives while full and no pop happens that cycle, the record is not written and drop_cnt increments, saturating at all-ones. retire_cnt counts only written records and wraps modulo 2^CNT_W.
- Simultaneous push and pop when full: in drop mode the push succeeds and nothing is dropped; in stall mode cm_ready uses registered full, so the push is not accepted.
- Output: tr_rec holds the head record stable while tr_valid && !tr_ready. Pop on tr_valid && tr_ready.
- Pointers are log2(DEPTH)+1 bits with natural wrap. full and empty are derived from the pointer MSB/LSB compare.
- State machine (2-bit):
  - RUN -> DRAIN when an accepted record has brk or ivd set. halt_cause is latched; ivd wins if both are set. The trapping record is itself enqueued.
  - DRAIN -> HALT when the FIFO becomes empty (registered empty, the cycle after the last pop).
  - HALT: halted=1. resume=1 -> RUN next cycle and halt_cause clears to 00.
  - resume outside HALT is ignored.
- Counters and FIFO state are unaffected by halt/resume.

Optional Feature:
- Macro: DBG_COMMIT_TRACE_DPI_EN.
- Defined: on each pop, at posedge clk, the block calls DPI-C functions:
  - dbg_trace_commit(pc, inst);
  - dbg_trace_gpr(addr, data) if gpr_wen;
  - dbg_trace_csr(addr, data) if csr_wen;
  - dbg_trace_halt(cause) on entry to HALT.
- Not defined: no DPI imports; the block is synthesizable and identical in port behaviour.

Test Plan:
- Reset then push 3 records (pc 0x80000000/4/8) with tr_ready=1 -> tr_valid rises 1 cycle after each push, records pop in order, retire_cnt=3.
- DEPTH=8, DROP_ON_FULL=0, tr_ready=0, push 10 -> cm_ready low after 8 accepted, retire_cnt=8; raise tr_ready -> remaining 2 accepted, 10 records out in order.
- DROP_ON_FULL=1, tr_ready=0, push 10 -> 8 stored, drop_cnt=2; repeat with simultaneous pop on the 9th -> drop_cnt increments only on the 10th.
- Push record with cm_brk=1 while 2 are queued -> cm_ready=0, 3 records drain, halted=1 the cycle after empty, halt_cause=01; pulse resume -> halted=0, cm_ready=1.
- Record with brk=1 and ivd=1 -> halt_cause=10.
- Assert reset asynchronously with 5 records queued and state DRAIN -> tr_valid=0, halted=0, counters 0 before the next clock edge.
